ser_tx: RTL and testbench

SER_TX -- requirements
Module: ser_tx

---
 rtl/ser_tx_pkg.sv | 16 +
 rtl/ser_cnt.sv | 33 +++
 rtl/ser_tx.sv | 99 +++++++++
 tb/tb_ser_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ser_tx_pkg.sv
// Shared types and constants for the ser_tx serializer.
package ser_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DW_DEF = 8;

   function automatic int cnt_w(input int dw);
      return (dw <= 1) ? 1 : $clog2(dw);
   endfunction

endpackage

// File: rtl/ser_cnt.sv
// Saturating up-counter with enable, synchronous clear and terminal count.
module ser_cnt #(
   parameter int            W   = 3,
   parameter logic [W-1:0]  MAX = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tc
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == MAX);

   // Holds at MAX instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !tc)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter, MSB first, with done pulse per word.
module ser_tx
   import ser_tx_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          cclk,
   input  logic          rst_n,
   input  logic          enb,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   output logic          sdo,
   output logic          sdo_valid,
   output logic          busy,
   output logic          done
);

   localparam int           CW   = cnt_w(DW);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   state_e        state_q, state_d;
   logic [DW-1:0] sh_q, sh_d;
   logic          accept;
   logic          cnt_en;
   logic          tc;

   assign accept = enb && load_valid && (state_q == IDLE);
   assign cnt_en = enb && (state_q == SHIFT);

   ser_cnt #(
      .W   (CW),
      .MAX (LAST)
   ) u_cnt (
      .clk   (cclk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .clr   (accept),
      .tc    (tc)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sh_d    = load_data;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (enb) begin
               sh_d = sh_q << 1;
               if (tc)
                  state_d = DONE;
            end
         end
         DONE: begin
            if (enb)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
      end
   end

   // Outputs depend on registered state only, so reset clears them at once.
   always_comb begin
      load_ready = 1'b0;
      sdo        = 1'b0;
      sdo_valid  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE:  load_ready = 1'b1;
         SHIFT: begin
            sdo       = sh_q[DW-1];
            sdo_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: load_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ser_tx.sv
// Directed self-checking bench for ser_tx at DW=8, DW=1 and DW=32.
module tb_ser_tx;

   logic cclk = 1'b0;
   always #5 cclk = ~cclk;

   logic rst_n;

   logic       enb8, lv8, lr8, sdo8, sv8, busy8, done8;
   logic [7:0] ld8;
   logic       enb1, lv1, lr1, sdo1, sv1, busy1, done1;
   logic [0:0] ld1;
   logic        enb32, lv32, lr32, sdo32, sv32, busy32, done32;
   logic [31:0] ld32;

   int n_chk = 0;
   int n_err = 0;

   ser_tx #(.DW(8)) u8 (
      .cclk(cclk), .rst_n(rst_n), .enb(enb8),
      .load_valid(lv8), .load_data(ld8), .load_ready(lr8),
      .sdo(sdo8), .sdo_valid(sv8), .busy(busy8), .done(done8)
   );

   ser_tx #(.DW(1)) u1 (
      .cclk(cclk), .rst_n(rst_n), .enb(enb1),
      .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
      .sdo(sdo1), .sdo_valid(sv1), .busy(busy1), .done(done1)
   );

   ser_tx #(.DW(32)) u32 (
      .cclk(cclk), .rst_n(rst_n), .enb(enb32),
      .load_valid(lv32), .load_data(ld32), .load_ready(lr32),
      .sdo(sdo32), .sdo_valid(sv32), .busy(busy32), .done(done32)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   // Status of the DW=8 unit packed as {load_ready, sdo_valid, busy, done}.
   function automatic logic [3:0] st8();
      return {lr8, sv8, busy8, done8};
   endfunction

   // Entered at the cycle-1 sample point after an accept; leaves at cycle 10.
   task automatic stream8(input string tag, input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), {31'd0, sdo8}, {31'd0, w[7-i]});
         chk($sformatf("%s_st%0d", tag, i), {28'd0, st8()}, 32'h6);
         tick();
      end
      chk({tag, "_done"}, {28'd0, st8()}, 32'h3);
      tick();
      chk({tag, "_idle"}, {28'd0, st8()}, 32'h8);
   endtask

   initial begin
      rst_n = 1'b0;
      enb8 = 1'b1;  lv8 = 1'b0;  ld8 = '0;
      enb1 = 1'b1;  lv1 = 1'b0;  ld1 = '0;
      enb32 = 1'b1; lv32 = 1'b0; ld32 = '0;
      #1;
      chk("reset_st8", {28'd0, st8()}, 32'h8);
      chk("reset_sdo8", {31'd0, sdo8}, 32'h0);
      chk("reset_st1", {28'd0, lr1, sv1, busy1, done1}, 32'h8);
      chk("reset_st32", {28'd0, lr32, sv32, busy32, done32}, 32'h8);
      tick();
      tick();
      rst_n = 1'b1;

      // 0xA5, accepted on the first edge after reset release.
      ld8 = 8'hA5; lv8 = 1'b1;
      tick();
      lv8 = 1'b0;
      stream8("a5", 8'hA5);

      // 0xFF with load_valid held and data changed to 0x00 while busy.
      ld8 = 8'hFF; lv8 = 1'b1;
      tick();
      ld8 = 8'h00;
      stream8("ff", 8'hFF);
      tick();
      lv8 = 1'b0;
      stream8("zero", 8'h00);

      // 0x3C with enb low for three edges after bit 2.
      ld8 = 8'h3C; lv8 = 1'b1;
      tick();
      lv8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("3c_bit%0d", i), {31'd0, sdo8}, {31'd0, ld8[7-i]});
         if (i < 2) tick();
      end
      enb8 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("3c_hold_sdo%0d", k), {31'd0, sdo8}, 32'h1);
         chk($sformatf("3c_hold_st%0d", k), {28'd0, st8()}, 32'h6);
      end
      enb8 = 1'b1;
      for (int i = 3; i < 8; i++) begin
         tick();
         chk($sformatf("3c_bit%0d", i), {31'd0, sdo8}, {31'd0, ld8[7-i]});
         chk($sformatf("3c_st%0d", i), {28'd0, st8()}, 32'h6);
      end
      tick();
      chk("3c_done_c12", {28'd0, st8()}, 32'h3);
      enb8 = 1'b0;
      tick();
      chk("3c_done_held", {28'd0, st8()}, 32'h3);
      enb8 = 1'b1;
      tick();
      chk("3c_idle", {28'd0, st8()}, 32'h8);
      enb8 = 1'b0; lv8 = 1'b1; ld8 = 8'hC3;
      tick();
      chk("noenb_no_accept", {28'd0, st8()}, 32'h8);
      enb8 = 1'b1; lv8 = 1'b0;

      // 0x81 interrupted by reset after bit 4, then 0x5A.
      ld8 = 8'h81; lv8 = 1'b1;
      tick();
      lv8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("81_bit%0d", i), {31'd0, sdo8}, {31'd0, ld8[7-i]});
         if (i < 4) tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_st", {28'd0, st8()}, 32'h8);
      chk("async_rst_sdo", {31'd0, sdo8}, 32'h0);
      tick();
      rst_n = 1'b1;
      ld8 = 8'h5A; lv8 = 1'b1;
      tick();
      lv8 = 1'b0;
      stream8("5a", 8'h5A);

      // DW=1: one SHIFT cycle, done on cycle 2.
      ld1 = 1'b1; lv1 = 1'b1;
      tick();
      lv1 = 1'b0;
      chk("dw1_c1", {28'd0, sdo1, sv1, busy1, done1}, 32'he);
      tick();
      chk("dw1_c2", {28'd0, sdo1, sv1, busy1, done1}, 32'h3);
      tick();
      chk("dw1_c3", {28'd0, lr1, sv1, busy1, done1}, 32'h8);

      // DW=32: 0x80000001, done on cycle 33.
      ld32 = 32'h8000_0001; lv32 = 1'b1;
      tick();
      lv32 = 1'b0;
      chk("dw32_first", {30'd0, sdo32, sv32}, 32'h3);
      for (int i = 1; i < 31; i++) begin
         tick();
         chk($sformatf("dw32_bit%0d", i), {30'd0, sdo32, sv32}, 32'h1);
      end
      tick();
      chk("dw32_last", {30'd0, sdo32, sv32}, 32'h3);
      tick();
      chk("dw32_done", {28'd0, lr32, sv32, busy32, done32}, 32'h3);
      tick();
      chk("dw32_idle", {28'd0, lr32, sv32, busy32, done32}, 32'h8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
